rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//   Parametrised N-channel, W-bit registered multiplexer with built-in arbitration.
//   Each input channel and the output use valid/ready handshakes.
//   Selects one requesting channel per cycle (round-robin or fixed priority) and holds it in a one-entry output register.
//   Shared-bus front end for the CPU datapath, e.g. merging writeback or memory-request sources onto one port.
// PARAMETERS
//   W   32  data width per channel, >=1
//   N   4   number of input channels, >=2 (need not be a power of two)
//   RR  1   1 = round-robin arbitration; 0 = fixed priority, lowest index wins
//   SW  derived localparam = max(1, clog2(N)); width of out_sel and the pointer (not user-set)
// PORTS
//   clk        in   1     rising-edge clock
//   reset      in   1     synchronous, active-high reset
//   in_valid   in   N     bit i: channel i presents a word
//   in_data    in   N*W   channel i data at [i*W +: W]
//   in_ready   out  N     bit i: channel i word accepted this cycle (combinational)
//   out_valid  out  1     output register holds a word
//   out_data   out  W     registered selected word
//   out_sel    out  SW    index of the channel that supplied out_data
//   out_ready  in   1     downstream accepts the word this cycle
// BEHAVIOUR
//   Reset (clk edge with reset=1): out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready forced to 0 while reset=1.
//   State: out_valid is the only state bit. EMPTY (0) or FULL (1); ptr is the round-robin pointer, 0..N-1.
//   load_ok = !out_valid || out_ready; all handshakes are evaluated at the rising clk edge.
//   Grant: one-hot over in_valid.
//     RR=1: search starts at ptr, increasing index, wrapping N-1 -> 0.
//     RR=0: search starts at 0.
//   in_ready[i] = load_ok && grant[i] && !reset. At most one bit of in_ready is set; it is 0 for channels that are not requesting.
//   Load (load_ok and any in_valid): out_data <= in_data[g]; out_sel <= g; out_valid <= 1.
//     If RR=1, ptr <= (g==N-1) ? 0 : g+1. The wrap is explicit, so non-power-of-two N works.
//   Idle (load_ok and no in_valid): out_valid <= 0; out_data, out_sel and ptr hold.
//   Stall (out_valid && !out_ready): out_valid, out_data and out_sel stay stable; in_ready = 0; ptr holds.
//   Simultaneous pop and load: a new word loads on the same edge the old one is consumed. Full throughput is 1 word/cycle.
//   Latency: 1 cycle from input handshake to out_valid.
//   Reset mid-operation: the held word is discarded with no handshake. The first grant after reset goes to the lowest requesting index.
//   An input channel must keep in_valid and in_data stable until its in_ready; the block does not check this.
// STRUCTURE
//   Shared constants header:
//     clog2 function
//     ARB_RR=1 and ARB_FIXED=0 mode constants
//   Sub-module rr_arbiter #(N, SW, RR): purely combinational.
//     Inputs: req[N], ptr[SW], en.
//     Outputs: one-hot gnt[N], binary idx[SW].
//   Top level contains only the output register, the pointer register and the data select loop.
//   No latches; every register is updated only on posedge clk.
// TESTING (N=4, W=32 unless noted; expected value held in a non-bitwise oracle model, compared with ===)
//   1. Reset for 2 cycles with in_valid=4'b1111
//      -> in_ready=0000, then out_valid=0, out_data=0, out_sel=0.
//   2. in_valid=0100, ch2 data=32'hA5A5_0002, out_ready=1
//      -> in_ready=0100; next cycle out_valid=1, out_data=A5A50002, out_sel=2.
//   3. RR=1, in_valid=1111 held, out_ready=1
//      -> out_sel sequence 0,1,2,3,0,1, one word per cycle, no bubbles.
//   4. out_ready=0 for 5 cycles while FULL
//      -> in_ready=0000, out_data/out_sel unchanged; out_ready=1 -> next channel after out_sel is granted.
//   5. RR=0, in_valid=1110 then 1111
//      -> out_sel=1 while ch0 idle, then always 0; N=3 build with RR=1, in_valid=111 -> out_sel 0,1,2,0.
//   6. reset=1 while FULL and out_ready=0
//      -> next edge out_valid=0; with in_valid=1010 after reset -> out_sel=1.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrated output mux.
package rr_arb_mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        for (v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational request arbiter: one-hot grant plus binary index.
// Round-robin mode searches upward from ptr with an explicit wrap so that
// non-power-of-two channel counts work; fixed mode always searches from 0.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = 2,
    parameter int RR = ARB_RR
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx
);

    // Walk the channels in priority order and grant the first requester.
    always_comb begin
        int            start;
        int            c;
        logic [SW-1:0] ci;
        logic          found;
        start = (RR == ARB_RR) ? int'(ptr) : 0;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        ci    = '0;
        for (int k = 0; k < N; k++) begin
            c = start + k;
            if (c >= N) c = c - N;
            ci = SW'(c);
            if (en && !found && req[ci]) begin
                found   = 1'b1;
                gnt[ci] = 1'b1;
                idx     = ci;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready multiplexer with built-in arbitration and a
// one-entry output register. Sustains one word per cycle when downstream
// is ready; a held word is dropped silently on reset.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int  W  = 32,
    parameter int  N  = 4,
    parameter int  RR = ARB_RR,
    localparam int SW = sel_w(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] gnt_idx;
    logic [N-1:0]  gnt;
    logic          load_ok;
    logic          any_gnt;
    logic [W-1:0]  sel_data;

    // The output register can take a word when empty or being drained.
    assign load_ok = !out_valid || out_ready;

    rr_arbiter #(
        .N  (N),
        .SW (SW),
        .RR (RR)
    ) u_arb (
        .req (in_valid),
        .ptr (ptr),
        .en  (load_ok && !reset),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // The grant is only raised when the word is actually taken.
    assign in_ready = gnt;
    assign any_gnt  = |gnt;

    // One-hot data select of the granted channel.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) sel_data = in_data[i*W +: W];
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_ok) begin
            if (any_gnt) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= gnt_idx;
                if (RR == ARB_RR) begin
                    ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: three builds (N=4 round-robin,
// N=4 fixed priority, N=3 round-robin) share one stimulus stream.
module tb_rr_arb_mux;

    localparam int W = 32;

    typedef struct {
        logic [31:0] data;
        int          sel;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [2:0]   ordy;

    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy2;
    logic        ov0, ov1, ov2;
    logic [31:0] od0, od1, od2;
    logic [1:0]  os0, os1, os2;

    logic [3:0]  rdy_a [3];
    logic        ov_a  [3];
    logic [31:0] od_a  [3];
    logic [1:0]  os_a  [3];

    int checks = 0;
    int errors = 0;

    bit   mvalid [3];
    int   mlast  [3];
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    rr_arb_mux #(.W(32), .N(4), .RR(1)) dut_rr (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0),
        .out_ready(ordy[0])
    );

    rr_arb_mux #(.W(32), .N(4), .RR(0)) dut_fx (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1),
        .out_ready(ordy[1])
    );

    rr_arb_mux #(.W(32), .N(3), .RR(1)) dut_n3 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2:0]), .in_data(in_data[95:0]),
        .in_ready(rdy2), .out_valid(ov2), .out_data(od2), .out_sel(os2),
        .out_ready(ordy[2])
    );

    assign rdy_a[0] = rdy0;
    assign rdy_a[1] = rdy1;
    assign rdy_a[2] = {1'b0, rdy2};
    assign ov_a[0]  = ov0;
    assign ov_a[1]  = ov1;
    assign ov_a[2]  = ov2;
    assign od_a[0]  = od0;
    assign od_a[1]  = od1;
    assign od_a[2]  = od2;
    assign os_a[0]  = os0;
    assign os_a[1]  = os1;
    assign os_a[2]  = os2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int d, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{32'h0, 0};
        case (d)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic clr_exp(input int d);
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    // Reference behaviour for one clock: which channel should be accepted,
    // and what the output register will then hold.
    task automatic step_model(input int d);
        int          n;
        bit          rr_mode;
        bit          lok;
        int          g;
        int          start;
        int          c;
        logic [3:0]  er;
        logic [3:0]  vbits;
        logic [127:0] sh;
        n       = (d == 2) ? 3 : 4;
        rr_mode = (d != 1);
        er      = '0;
        chk($sformatf("dut%0d out_valid", d), 32'(ov_a[d]), 32'(mvalid[d]));
        if (reset) begin
            clr_exp(d);
            mvalid[d] = 1'b0;
            mlast[d]  = -1;
        end else begin
            lok = !mvalid[d] || ordy[d];
            if (lok) begin
                g     = -1;
                start = (rr_mode && mlast[d] >= 0) ? (mlast[d] + 1) % n : 0;
                for (int k = 0; k < n; k++) begin
                    c     = (start + k) % n;
                    vbits = in_valid >> c;
                    if (g < 0 && vbits[0]) g = c;
                end
                if (g >= 0) begin
                    er = 4'b0001 << g;
                    sh = in_data >> (g * W);
                    push_exp(d, '{sh[31:0], g});
                    mvalid[d] = 1'b1;
                    mlast[d]  = g;
                end else begin
                    mvalid[d] = 1'b0;
                end
            end
        end
        chk($sformatf("dut%0d in_ready", d), 32'(rdy_a[d]), 32'(er));
    endtask

    function automatic logic [127:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic cycle(input bit rst, input logic [3:0] iv, input logic [2:0] orv,
                         input logic [127:0] dat);
        @(negedge clk);
        reset    = rst;
        in_valid = iv;
        ordy     = orv;
        in_data  = dat;
        #2;
        for (int d = 0; d < 3; d++) step_model(d);
    endtask

    task automatic chk_reset_vals();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d reset out_valid", d), 32'(ov_a[d]), 32'h0);
            chk($sformatf("dut%0d reset out_data", d), od_a[d], 32'h0);
            chk($sformatf("dut%0d reset out_sel", d), 32'(os_a[d]), 32'h0);
        end
    endtask

    // Monitor: whenever a DUT hands off a word, it must be the oldest expected one.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            #3;
            if (reset === 1'b0) begin
                for (int d = 0; d < 3; d++) begin
                    if (ov_a[d] === 1'b1 && ordy[d] === 1'b1) begin
                        pop_exp(d, e, ok);
                        if (!ok) begin
                            checks++;
                            errors++;
                            $display("FAIL dut%0d unexpected word: got %h sel %0d expected none",
                                     d, od_a[d], os_a[d]);
                        end else begin
                            chk($sformatf("dut%0d out_data", d), od_a[d], e.data);
                            chk($sformatf("dut%0d out_sel", d), 32'(os_a[d]), 32'(e.sel));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [127:0] dat;
        bit           rst;
        logic [3:0]   iv;
        logic [2:0]   orv;
        reset    = 1'b1;
        in_valid = '0;
        ordy     = '0;
        in_data  = '0;
        for (int d = 0; d < 3; d++) begin
            mvalid[d] = 1'b0;
            mlast[d]  = -1;
        end
        repeat (2) @(negedge clk);

        // Reset held with every channel requesting.
        cycle(1'b1, 4'b1111, 3'b111, rnd_data());
        cycle(1'b1, 4'b1111, 3'b111, rnd_data());
        chk_reset_vals();

        // Single requester on channel 2.
        dat = rnd_data();
        dat[64 +: 32] = 32'hA5A5_0002;
        cycle(1'b0, 4'b0100, 3'b111, dat);
        cycle(1'b0, 4'b0000, 3'b111, rnd_data());
        chk("ch2 word out_data", od0, 32'hA5A5_0002);
        chk("ch2 word out_sel", 32'(os0), 32'd2);

        // Everyone requesting, downstream always ready.
        repeat (8) cycle(1'b0, 4'b1111, 3'b111, rnd_data());

        // Downstream stalls while full, then releases.
        repeat (5) cycle(1'b0, 4'b1111, 3'b000, rnd_data());
        repeat (2) cycle(1'b0, 4'b1111, 3'b111, rnd_data());

        // Channel 0 idle, then joins.
        repeat (3) cycle(1'b0, 4'b1110, 3'b111, rnd_data());
        repeat (4) cycle(1'b0, 4'b1111, 3'b111, rnd_data());

        // Reset while full and stalled; first grant afterwards is lowest requester.
        cycle(1'b0, 4'b1111, 3'b000, rnd_data());
        cycle(1'b1, 4'b1111, 3'b000, rnd_data());
        cycle(1'b0, 4'b1010, 3'b111, rnd_data());
        chk_reset_vals();
        cycle(1'b0, 4'b0000, 3'b111, rnd_data());

        // Randomised traffic with occasional resets.
        repeat (1500) begin
            rst = ($urandom_range(0, 99) == 0);
            iv  = 4'($urandom());
            for (int d = 0; d < 3; d++) orv[d] = ($urandom_range(0, 3) != 0);
            cycle(rst, iv, orv, rnd_data());
        end

        // Drain everything and confirm nothing is left outstanding.
        repeat (3) cycle(1'b0, 4'b0000, 3'b111, rnd_data());
        @(negedge clk);
        #4;
        chk("dut0 drained", 32'(q0.size()), 32'd0);
        chk("dut1 drained", 32'(q1.size()), 32'd0);
        chk("dut2 drained", 32'(q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
